karplus_pluck_loader: RTL

KARPLUS_PLUCK_LOADER -- requirements
Module: karplus_pluck_loader

---
 rtl/karplus_pluck_loader.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/karplus_pluck_loader.sv
// Loads a Karplus-Strong delay line with LFSR noise words, strobing each word
// with noise_pulse, then hands the latched tap/divisor to the synthesizer.
module karplus_pluck_loader #(
  parameter logic [15:0] LFSR_SEED  = 16'hACE1,
  parameter int unsigned PULSE_HALF = 4,
  parameter int unsigned MAX_LEN    = 700
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        pluck_start,
  input  logic [9:0]  pluck_len,
  input  logic [9:0]  pluck_sel,
  input  logic [31:0] pluck_div,
  output logic [15:0] noise,
  output logic        noise_en,
  output logic        noise_pulse,
  output logic [9:0]  sel_nota,
  output logic [31:0] div_freq_in,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [15:0] SEED_EFF   = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam logic [7:0]  PHASE_LAST = 8'(PULSE_HALF - 1);

  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, RELEASE} state_t;

  state_t      state_q, state_d;
  logic [7:0]  phase_q, phase_d;
  logic [9:0]  cnt_q, cnt_d;
  logic [9:0]  len_q, len_d;
  logic [9:0]  sel_q, sel_d;
  logic [31:0] div_q, div_d;

  logic [15:0] noise_d;
  logic        noise_en_d, noise_pulse_d, busy_d, done_d, err_d;
  logic [9:0]  sel_nota_d;
  logic [31:0] div_freq_in_d;

  logic        len_ok;
  logic        phase_last;
  logic [15:0] lfsr_step;

  assign len_ok     = (pluck_len != 10'd0) && (32'(pluck_len) <= MAX_LEN);
  assign phase_last = (phase_q == PHASE_LAST);
  assign lfsr_step  = {1'b0, noise[15:1]} ^ (noise[0] ? 16'hB400 : 16'h0000);

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_d       = state_q;
    phase_d       = phase_q;
    cnt_d         = cnt_q;
    len_d         = len_q;
    sel_d         = sel_q;
    div_d         = div_q;
    noise_d       = noise;
    noise_en_d    = noise_en;
    noise_pulse_d = noise_pulse;
    busy_d        = busy;
    done_d        = 1'b0;
    err_d         = 1'b0;
    sel_nota_d    = sel_nota;
    div_freq_in_d = div_freq_in;

    case (state_q)
      IDLE: begin
        if (pluck_start) begin
          if (len_ok) begin
            len_d      = pluck_len;
            sel_d      = pluck_sel;
            div_d      = pluck_div;
            cnt_d      = 10'd0;
            phase_d    = 8'd0;
            noise_en_d = 1'b1;
            busy_d     = 1'b1;
            state_d    = SETUP;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      SETUP: begin
        if (phase_last) begin
          phase_d       = 8'd0;
          noise_pulse_d = 1'b1;
          state_d       = HIGH;
        end else begin
          phase_d = phase_q + 8'd1;
        end
      end
      HIGH: begin
        // The LFSR steps only on the falling side of the strobe, keeping noise
        // stable around every rising edge.
        if (phase_last) begin
          phase_d       = 8'd0;
          noise_pulse_d = 1'b0;
          cnt_d         = cnt_q + 10'd1;
          noise_d       = lfsr_step;
          state_d       = LOW;
        end else begin
          phase_d = phase_q + 8'd1;
        end
      end
      LOW: begin
        if (phase_last) begin
          phase_d = 8'd0;
          if (cnt_q == len_q) begin
            noise_en_d    = 1'b0;
            done_d        = 1'b1;
            sel_nota_d    = sel_q;
            div_freq_in_d = div_q;
            state_d       = RELEASE;
          end else begin
            noise_pulse_d = 1'b1;
            state_d       = HIGH;
          end
        end else begin
          phase_d = phase_q + 8'd1;
        end
      end
      RELEASE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d       = IDLE;
        noise_en_d    = 1'b0;
        noise_pulse_d = 1'b0;
        busy_d        = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      phase_q     <= 8'd0;
      cnt_q       <= 10'd0;
      len_q       <= 10'd0;
      sel_q       <= 10'd0;
      div_q       <= 32'd0;
      noise       <= SEED_EFF;
      noise_en    <= 1'b0;
      noise_pulse <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      sel_nota    <= 10'd0;
      div_freq_in <= 32'd0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      sel_q       <= sel_d;
      div_q       <= div_d;
      noise       <= noise_d;
      noise_en    <= noise_en_d;
      noise_pulse <= noise_pulse_d;
      busy        <= busy_d;
      done        <= done_d;
      err         <= err_d;
      sel_nota    <= sel_nota_d;
      div_freq_in <= div_freq_in_d;
    end
  end

endmodule
